// File: rtl/timestamp_query_arbiter_if.sv
// Request/response handshake bundle for timestamp_query_arbiter.
// rsp_epoch_out exists only when TIMESTAMP_QUERY_ARBITER_EPOCH_EN is defined.
interface timestamp_query_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]  req_valid_in;
    logic [NUM_REQ-1:0]  req_ready_out;
    logic                rsp_valid_out;
    logic                rsp_ready_in;
    logic [ID_WIDTH-1:0] rsp_id_out;
    logic [WIDTH-1:0]    rsp_timestamp_out;
`ifdef TIMESTAMP_QUERY_ARBITER_EPOCH_EN
    logic [7:0]          rsp_epoch_out;

    modport master (
        output req_valid_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_id_out, rsp_timestamp_out, rsp_epoch_out
    );
    modport slave (
        input  req_valid_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_id_out, rsp_timestamp_out, rsp_epoch_out
    );
`else
    modport master (
        output req_valid_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_id_out, rsp_timestamp_out
    );
    modport slave (
        input  req_valid_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_id_out, rsp_timestamp_out
    );
`endif
endinterface

// File: rtl/timestamp_query_arbiter.sv
// Shared free-running counter with round-robin timestamp queries and a 1-deep response slot.
// Optional wrap epoch: define TIMESTAMP_QUERY_ARBITER_EPOCH_EN.
module timestamp_query_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic count_enable_in,
    input  logic clear_in,
    timestamp_query_arbiter_if.slave bus
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [WIDTH-1:0]    counter;
    logic [ID_WIDTH-1:0] ptr;
    logic                rsp_valid;
    logic [ID_WIDTH-1:0] rsp_id;
    logic [WIDTH-1:0]    rsp_timestamp;

    logic                slot_free;
    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [NUM_REQ-1:0]  grant_vec;

    assign slot_free = !rsp_valid || bus.rsp_ready_in;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_in[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_in[i] && (ID_WIDTH'(i) >= ptr)) begin
                grant_idx = ID_WIDTH'(i);
            end
        end
        if (!slot_free) begin
            grant_any = 1'b0;
        end
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = grant_any && (grant_idx == ID_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (clear_in) begin
            counter <= '0;
        end else if (count_enable_in) begin
            counter <= counter + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_timestamp <= '0;
        end else if (grant_any) begin
            ptr           <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
            rsp_valid     <= 1'b1;
            rsp_id        <= grant_idx;
            rsp_timestamp <= counter;
        end else if (bus.rsp_ready_in) begin
            rsp_valid     <= 1'b0;
        end
    end

`ifdef TIMESTAMP_QUERY_ARBITER_EPOCH_EN
    logic [7:0] epoch;
    logic [7:0] rsp_epoch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch <= '0;
        end else if (clear_in) begin
            epoch <= '0;
        end else if (count_enable_in && (counter == '1)) begin
            epoch <= epoch + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_epoch <= '0;
        end else if (grant_any) begin
            rsp_epoch <= epoch;
        end
    end

    assign bus.rsp_epoch_out = rsp_epoch;
`endif

    assign bus.req_ready_out     = grant_vec;
    assign bus.rsp_valid_out     = rsp_valid;
    assign bus.rsp_id_out        = rsp_id;
    assign bus.rsp_timestamp_out = rsp_timestamp;

endmodule
